// File: rtl/game_defs.sv
// Shared key codes, event codes and state encodings for the 1A2B game front end.
// core_fsm reuses the commit/submit event codes from here.
package game_defs;

    localparam logic [3:0] KEY_BKSP   = 4'd10;
    localparam logic [3:0] KEY_MODE   = 4'd11;
    localparam logic [3:0] KEY_COMMIT = 4'd12;
    localparam logic [3:0] KEY_SUBMIT = 4'd13;
    localparam logic [3:0] KEY_CLEAR  = 4'd14;

    localparam logic [2:0] EV_NONE   = 3'd0;
    localparam logic [2:0] EV_DIGIT  = 3'd1;
    localparam logic [2:0] EV_REJECT = 3'd2;
    localparam logic [2:0] EV_BKSP   = 3'd3;
    localparam logic [2:0] EV_CLEAR  = 3'd4;
    localparam logic [2:0] EV_COMMIT = 3'd5;
    localparam logic [2:0] EV_SUBMIT = 3'd6;

    localparam logic [3:0]  BLANK_NIBBLE = 4'hF;
    localparam logic [15:0] BLANK_ENTRY  = {4{BLANK_NIBBLE}};

    typedef enum logic [1:0] {
        DB_RELEASED,
        DB_ARMING,
        DB_HELD,
        DB_RELEASING
    } db_state_e;

    typedef enum logic [1:0] {
        EN_EMPTY,
        EN_ENTRY,
        EN_FULL,
        EN_COMMITTED
    } entry_state_e;

    // Blank nibbles never match because digits are limited to 0-9.
    function automatic logic has_digit(input logic [15:0] value, input logic [3:0] digit);
        logic found;
        found = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (value[i*4 +: 4] == digit) found = 1'b1;
        end
        return found;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Turns the scanner's level key report into a single registered event per press.
// A press needs DEBOUNCE identical samples; a release needs DEBOUNCE low samples.
module key_debounce
    import game_defs::*;
#(
    parameter int unsigned DEBOUNCE = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_raw_valid,
    input  logic [3:0] key_raw_code,
    output logic       key_ev,
    output logic [3:0] key_code
);

    localparam logic [3:0] DB_MAX = 4'(DEBOUNCE);

    db_state_e  state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [3:0] code_q, code_d;
    logic       ev_q, ev_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= DB_RELEASED;
            cnt_q   <= 4'd0;
            code_q  <= 4'd0;
            ev_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            code_q  <= code_d;
            ev_q    <= ev_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        code_d  = code_q;
        ev_d    = 1'b0;
        case (state_q)
            DB_RELEASED: begin
                if (key_raw_valid) begin
                    code_d  = key_raw_code;
                    cnt_d   = 4'd1;
                    state_d = DB_ARMING;
                end
            end
            DB_ARMING: begin
                if (!key_raw_valid) begin
                    state_d = DB_RELEASED;
                end else if (key_raw_code != code_q) begin
                    code_d = key_raw_code;
                    cnt_d  = 4'd1;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            DB_HELD: begin
                if (!key_raw_valid) begin
                    cnt_d   = 4'd1;
                    state_d = DB_RELEASING;
                end
            end
            DB_RELEASING: begin
                if (key_raw_valid) begin
                    state_d = DB_HELD;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            default: state_d = DB_RELEASED;
        endcase

        // Threshold checks share one place so DEBOUNCE=1 fires on the first sample.
        if (state_d == DB_ARMING && cnt_d >= DB_MAX) begin
            state_d = DB_HELD;
            ev_d    = 1'b1;
        end else if (state_d == DB_RELEASING && cnt_d >= DB_MAX) begin
            state_d = DB_RELEASED;
        end
    end

    assign key_ev   = ev_q;
    assign key_code = code_q;

endmodule

// File: rtl/key_entry_ctrl.sv
// Keypad front end: debounced key events build a 4-digit BCD entry and
// produce the event code, entry value and display mode consumed by core_fsm.
module key_entry_ctrl
    import game_defs::*;
#(
    parameter int unsigned DEBOUNCE = 4,
    parameter int unsigned NO_DUP   = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        key_raw_valid,
    input  logic [3:0]  key_raw_code,
    input  logic        off,
    output logic        pressed,
    output logic [2:0]  key_in_state,
    output logic [15:0] value_out,
    output logic [1:0]  key_in_mode
);

    logic       db_ev;
    logic [3:0] db_code;

    key_debounce #(
        .DEBOUNCE(DEBOUNCE)
    ) u_debounce (
        .clk          (clk),
        .rst          (rst),
        .key_raw_valid(key_raw_valid),
        .key_raw_code (key_raw_code),
        .key_ev       (db_ev),
        .key_code     (db_code)
    );

    entry_state_e state_q, state_d;
    logic [2:0]   count_q, count_d;
    logic [15:0]  value_q, value_d;
    logic [1:0]   mode_q, mode_d;
    logic         pressed_q, pressed_d;
    logic [2:0]   ev_code_q, ev_code_d;
    logic         submit_q, submit_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= EN_EMPTY;
            count_q   <= 3'd0;
            value_q   <= BLANK_ENTRY;
            mode_q    <= 2'd0;
            pressed_q <= 1'b0;
            ev_code_q <= EV_NONE;
            submit_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            value_q   <= value_d;
            mode_q    <= mode_d;
            pressed_q <= pressed_d;
            ev_code_q <= ev_code_d;
            submit_q  <= submit_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        value_d   = value_q;
        mode_d    = mode_q;
        pressed_d = db_ev;
        ev_code_d = EV_NONE;
        submit_d  = 1'b0;

        // A submitted entry stays visible for the code-6 cycle, then blanks here.
        if (submit_q) begin
            state_d = EN_EMPTY;
            count_d = 3'd0;
            value_d = BLANK_ENTRY;
        end

        if (db_ev && !off) begin
            if (db_code <= 4'd9) begin
                if ((state_d == EN_EMPTY || state_d == EN_ENTRY) &&
                    !(NO_DUP != 0 && has_digit(value_d, db_code))) begin
                    value_d   = {value_d[11:0], db_code};
                    count_d   = count_d + 3'd1;
                    state_d   = (count_d == 3'd4) ? EN_FULL : EN_ENTRY;
                    ev_code_d = EV_DIGIT;
                end else begin
                    ev_code_d = EV_REJECT;
                end
            end else begin
                case (db_code)
                    KEY_BKSP: begin
                        if (count_d != 3'd0 && state_d != EN_COMMITTED) begin
                            value_d   = {BLANK_NIBBLE, value_d[15:4]};
                            count_d   = count_d - 3'd1;
                            state_d   = (count_d == 3'd0) ? EN_EMPTY : EN_ENTRY;
                            ev_code_d = EV_BKSP;
                        end else begin
                            ev_code_d = EV_REJECT;
                        end
                    end
                    KEY_MODE: mode_d = (mode_q == 2'd2) ? 2'd0 : mode_q + 2'd1;
                    KEY_COMMIT: begin
                        if (state_d == EN_FULL) begin
                            state_d   = EN_COMMITTED;
                            ev_code_d = EV_COMMIT;
                        end else begin
                            ev_code_d = EV_REJECT;
                        end
                    end
                    KEY_SUBMIT: begin
                        if (state_d == EN_COMMITTED) begin
                            submit_d  = 1'b1;
                            ev_code_d = EV_SUBMIT;
                        end else begin
                            ev_code_d = EV_REJECT;
                        end
                    end
                    KEY_CLEAR: begin
                        state_d   = EN_EMPTY;
                        count_d   = 3'd0;
                        value_d   = BLANK_ENTRY;
                        ev_code_d = EV_CLEAR;
                    end
                    default: ev_code_d = EV_NONE;
                endcase
            end
        end
    end

    assign pressed      = pressed_q;
    assign key_in_state = ev_code_q;
    assign value_out    = value_q;
    assign key_in_mode  = mode_q;

endmodule

// File: tb/tb_key_entry_ctrl.sv
// Directed bench for key_entry_ctrl with DEBOUNCE=4, NO_DUP=1.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_key_entry_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        key_raw_valid;
    logic [3:0]  key_raw_code;
    logic        off;
    logic        pressed;
    logic [2:0]  key_in_state;
    logic [15:0] value_out;
    logic [1:0]  key_in_mode;

    int compared   = 0;
    int mismatched = 0;

    logic [15:0] last_val_pulse;
    logic [15:0] last_val_next;

    key_entry_ctrl #(
        .DEBOUNCE(4),
        .NO_DUP  (1)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .key_raw_valid(key_raw_valid),
        .key_raw_code (key_raw_code),
        .off          (off),
        .pressed      (pressed),
        .key_in_state (key_in_state),
        .value_out    (value_out),
        .key_in_mode  (key_in_mode)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        assert (observed === expected)
        else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Presses a key for 'hold' samples, releases it for 'rel' samples and checks
    // the pulse count, pulse timing (5th falling edge), event code and final value.
    task automatic press_key(input string tag, input logic [3:0] code, input int hold, input int rel,
                             input int exp_pulses, input logic [2:0] exp_code,
                             input logic [15:0] exp_value);
        int          pulses;
        int          pulse_at;
        logic [2:0]  code_seen;
        logic        prev;
        pulses    = 0;
        pulse_at  = 0;
        code_seen = 3'd0;
        prev      = 1'b0;
        key_raw_valid = 1'b1;
        key_raw_code  = code;
        for (int i = 1; i <= hold + rel; i++) begin
            @(negedge clk);
            if (prev) last_val_next = value_out;
            prev = pressed;
            if (pressed) begin
                pulses++;
                if (pulses == 1) begin
                    pulse_at       = i;
                    code_seen      = key_in_state;
                    last_val_pulse = value_out;
                end
            end
            if (i == hold) key_raw_valid = 1'b0;
        end
        check({tag, ".pulses"}, 32'(pulses), 32'(exp_pulses));
        if (exp_pulses == 1) begin
            check({tag, ".pulse_at"}, 32'(pulse_at), 32'd5);
            check({tag, ".code"}, 32'(code_seen), 32'(exp_code));
        end
        check({tag, ".value"}, 32'(value_out), 32'(exp_value));
    endtask

    initial begin
        int pulses;
        int pulse_at;
        logic [2:0] code_seen;

        rst           = 1'b1;
        key_raw_valid = 1'b0;
        key_raw_code  = 4'd0;
        off           = 1'b0;
        last_val_pulse = 16'h0;
        last_val_next  = 16'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset.pressed", 32'(pressed), 32'd0);
        check("reset.state", 32'(key_in_state), 32'd0);
        check("reset.value", 32'(value_out), 32'hFFFF);
        check("reset.mode", 32'(key_in_mode), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        press_key("d1", 4'd1, 6, 6, 1, 3'd1, 16'hFFF1);
        press_key("d2", 4'd2, 6, 6, 1, 3'd1, 16'hFF12);
        press_key("d3", 4'd3, 6, 6, 1, 3'd1, 16'hF123);
        press_key("d4", 4'd4, 6, 6, 1, 3'd1, 16'h1234);
        press_key("short5", 4'd5, 3, 6, 0, 3'd0, 16'h1234);
        press_key("full_digit", 4'd6, 6, 6, 1, 3'd2, 16'h1234);
        press_key("commit", 4'd12, 6, 6, 1, 3'd5, 16'h1234);
        press_key("submit", 4'd13, 6, 6, 1, 3'd6, 16'hFFFF);
        check("submit.val_at_pulse", 32'(last_val_pulse), 32'h1234);
        check("submit.val_next", 32'(last_val_next), 32'hFFFF);

        press_key("hold7", 4'd7, 20, 6, 1, 3'd1, 16'hFFF7);
        press_key("clear", 4'd14, 6, 6, 1, 3'd4, 16'hFFFF);
        press_key("bksp_empty", 4'd10, 6, 6, 1, 3'd2, 16'hFFFF);
        press_key("e1", 4'd1, 6, 6, 1, 3'd1, 16'hFFF1);
        press_key("e2", 4'd2, 6, 6, 1, 3'd1, 16'hFF12);
        press_key("dup2", 4'd2, 6, 6, 1, 3'd2, 16'hFF12);
        press_key("bksp", 4'd10, 6, 6, 1, 3'd3, 16'hFFF1);
        press_key("e2b", 4'd2, 6, 6, 1, 3'd1, 16'hFF12);
        press_key("e3", 4'd3, 6, 6, 1, 3'd1, 16'hF123);
        press_key("commit3", 4'd12, 6, 6, 1, 3'd2, 16'hF123);

        off = 1'b1;
        press_key("off9", 4'd9, 6, 6, 1, 3'd0, 16'hF123);
        off = 1'b0;

        press_key("mode1", 4'd11, 6, 6, 1, 3'd0, 16'hF123);
        check("mode1.mode", 32'(key_in_mode), 32'd1);
        press_key("mode2", 4'd11, 6, 6, 1, 3'd0, 16'hF123);
        check("mode2.mode", 32'(key_in_mode), 32'd2);
        press_key("mode3", 4'd11, 6, 6, 1, 3'd0, 16'hF123);
        check("mode3.mode", 32'(key_in_mode), 32'd0);
        press_key("mode4", 4'd11, 6, 6, 1, 3'd0, 16'hF123);
        check("mode4.mode", 32'(key_in_mode), 32'd1);

        press_key("clear2", 4'd14, 6, 6, 1, 3'd4, 16'hFFFF);
        press_key("r3", 4'd3, 6, 6, 1, 3'd1, 16'hFFF3);
        press_key("r4", 4'd4, 6, 6, 1, 3'd1, 16'hFF34);

        // Reset while key 5 is mid-debounce, keep it held through and after reset.
        key_raw_valid = 1'b1;
        key_raw_code  = 4'd5;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid.value", 32'(value_out), 32'hFFFF);
        check("rst_mid.pressed", 32'(pressed), 32'd0);
        check("rst_mid.mode", 32'(key_in_mode), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        pulses    = 0;
        pulse_at  = 0;
        code_seen = 3'd0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (pressed) begin
                pulses++;
                if (pulses == 1) begin
                    pulse_at  = i;
                    code_seen = key_in_state;
                end
            end
        end
        key_raw_valid = 1'b0;
        repeat (6) @(negedge clk);
        check("post_rst.pulses", 32'(pulses), 32'd1);
        check("post_rst.pulse_at", 32'(pulse_at), 32'd5);
        check("post_rst.code", 32'(code_seen), 32'd1);
        check("post_rst.value", 32'(value_out), 32'hFFF5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
